// File: rtl/source_buffer_pkg.sv
// Shared constants and types for the ping-pong source feature buffer.
package source_buffer_pkg;
   localparam int SB_WL    = 32;
   localparam int SB_NUM   = 128;
   localparam int SB_DEPTH = 1024;

   typedef logic [SB_WL*SB_NUM-1:0] feat_vec_t;
   typedef logic                    bank_sel_t;

   // Per-request read context carried alongside the RAM latency.
   typedef struct packed {
      bank_sel_t bank;
      logic      oor;
      logic      hit;
   } rd_res_t;

   typedef struct packed {
      logic    vld;
      rd_res_t res;
   } rd_tag_t;

   // Out-of-range flag at reset forces q to zero until the first real result.
   localparam rd_res_t RD_RES_RST = '{bank: 1'b0, oor: 1'b1, hit: 1'b0};
endpackage

// File: rtl/source_feature_buffer_if.sv
// Loader/PE-side bus of the source feature buffer: two write ports, two read ports, bank control.
interface source_feature_buffer_if
   import source_buffer_pkg::*;
#(
   parameter int VW = SB_WL*SB_NUM,
   parameter int AW = $clog2(SB_DEPTH)
);
   logic [VW-1:0] data_a, data_b, q_a, q_b;
   logic [AW-1:0] wradd_a, wradd_b, radd_a, radd_b;
   logic          wren_a, wren_b, rden_a, rden_b, swap;
   logic          qvalid_a, qvalid_b, hit_a, hit_b, wr_bank, collision;

   modport master (
      output data_a, wradd_a, wren_a, data_b, wradd_b, wren_b,
             radd_a, rden_a, radd_b, rden_b, swap,
      input  q_a, q_b, qvalid_a, qvalid_b, hit_a, hit_b, wr_bank, collision
   );
   modport slave (
      input  data_a, wradd_a, wren_a, data_b, wradd_b, wren_b,
             radd_a, rden_a, radd_b, rden_b, swap,
      output q_a, q_b, qvalid_a, qvalid_b, hit_a, hit_b, wr_bank, collision
   );
endinterface

// File: rtl/sb_bank_ram.sv
// One 2W/2R feature bank; read data registered once, plus a second stage when RD_LAT=2.
module sb_bank_ram #(
   parameter int WL     = 32,
   parameter int NUM    = 128,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH),
   parameter int RD_LAT = 1
) (
   input  logic                   clock,
   input  logic [1:0]             we,
   input  logic [1:0][AW-1:0]     wadd,
   input  logic [1:0][WL*NUM-1:0] wdat,
   input  logic [1:0]             re,
   input  logic [1:0][AW-1:0]     radd,
   output logic [1:0][WL*NUM-1:0] rdat
);
   logic [WL*NUM-1:0]       mem [DEPTH];
   logic [1:0][WL*NUM-1:0]  s1;

   // Write collisions are already resolved upstream, so port order is irrelevant.
   always_ff @(posedge clock) begin
      for (int p = 0; p < 2; p++) begin
         if (we[p]) mem[wadd[p]] <= wdat[p];
         if (re[p]) s1[p] <= mem[radd[p]];
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic [1:0]             re_q;
      logic [1:0][WL*NUM-1:0] s2;
      always_ff @(posedge clock) begin
         re_q <= re;
         for (int p = 0; p < 2; p++)
            if (re_q[p]) s2[p] <= s1[p];
      end
      assign rdat = s2;
   end else begin : g_lat1
      assign rdat = s1;
   end
endmodule

// File: rtl/source_feature_buffer.sv
// Ping-pong source feature buffer: loader writes bank wr_bank while PEs read the other bank.
module source_feature_buffer
   import source_buffer_pkg::*;
#(
   parameter int WL     = SB_WL,
   parameter int NUM    = SB_NUM,
   parameter int DEPTH  = SB_DEPTH,
   parameter int AW     = $clog2(DEPTH),
   parameter int RD_LAT = 1
) (
   input logic                    clock,
   input logic                    reset_n,
   source_feature_buffer_if.slave bus
);
   localparam int           VW      = WL*NUM;
   localparam logic [AW:0]  DEPTH_W = (AW+1)'(DEPTH);

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_W;
   endfunction

   logic [1:0]              wreq, wen, rreq, rin;
   logic [1:0][AW-1:0]      wadd, radd;
   logic [1:0][VW-1:0]      wdat, q;
   logic [1:0][1:0][VW-1:0] rdat;
   logic [1:0][DEPTH-1:0]   tag_q;
   bank_sel_t               wr_bank_q, rd_bank;
   logic                    same_addr, collision_q;
   rd_tag_t [1:0]           rd_req, fin;
   rd_tag_t [1:0][RD_LAT-1:0] rd_pipe;
   rd_res_t [1:0]           held_q, sel;

   assign wreq = {bus.wren_b, bus.wren_a};
   assign wadd = {bus.wradd_b, bus.wradd_a};
   assign wdat = {bus.data_b, bus.data_a};
   assign rreq = {bus.rden_b, bus.rden_a};
   assign radd = {bus.radd_b, bus.radd_a};

   assign rd_bank   = ~wr_bank_q;
   assign same_addr = (wadd[0] == wadd[1]);
   assign rin       = {in_range(radd[1]), in_range(radd[0])};
   // Port A wins a same-address write; B is dropped.
   assign wen[0]    = wreq[0] & in_range(wadd[0]);
   assign wen[1]    = wreq[1] & in_range(wadd[1]) & ~(wen[0] & same_addr);

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_req[p].vld      = rreq[p];
         rd_req[p].res.bank = rd_bank;
         rd_req[p].res.oor  = ~rin[p];
         rd_req[p].res.hit  = rin[p] & tag_q[rd_bank][radd[p]];
         fin[p] = rd_pipe[p][RD_LAT-1];
         sel[p] = fin[p].vld ? fin[p].res : held_q[p];
         q[p]   = sel[p].oor ? '0 : rdat[sel[p].bank][p];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank_q   <= 1'b0;
         tag_q       <= '0;
         collision_q <= 1'b0;
         rd_pipe     <= '0;
         held_q      <= {2{RD_RES_RST}};
      end else begin
         collision_q <= wen[0] & wreq[1] & same_addr;
         for (int p = 0; p < 2; p++) begin
            if (wen[p]) tag_q[wr_bank_q][wadd[p]] <= 1'b1;
            rd_pipe[p][0] <= rd_req[p];
            for (int s = 1; s < RD_LAT; s++) rd_pipe[p][s] <= rd_pipe[p][s-1];
            if (fin[p].vld) held_q[p] <= fin[p].res;
         end
         // Swap clears the tags of the bank about to become the write bank.
         if (bus.swap) begin
            tag_q[rd_bank] <= '0;
            wr_bank_q      <= rd_bank;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic [1:0] bank_we, bank_re;
      assign bank_we = (wr_bank_q == bank_sel_t'(b)) ? wen : 2'b00;
      assign bank_re = (rd_bank == bank_sel_t'(b)) ? (rreq & rin) : 2'b00;
      sb_bank_ram #(
         .WL(WL), .NUM(NUM), .DEPTH(DEPTH), .AW(AW), .RD_LAT(RD_LAT)
      ) u_ram (
         .clock (clock),
         .we    (bank_we),
         .wadd  (wadd),
         .wdat  (wdat),
         .re    (bank_re),
         .radd  (radd),
         .rdat  (rdat[b])
      );
   end

   assign bus.q_a       = q[0];
   assign bus.q_b       = q[1];
   assign bus.qvalid_a  = fin[0].vld;
   assign bus.qvalid_b  = fin[1].vld;
   assign bus.hit_a     = sel[0].hit;
   assign bus.hit_b     = sel[1].hit;
   assign bus.wr_bank   = wr_bank_q;
   assign bus.collision = collision_q;
endmodule

// File: tb/tb_source_feature_buffer.sv
// Directed bench: RD_LAT=1 instance driven from a vector table, RD_LAT=2 instance by hand sequences.
module tb_source_feature_buffer;
   localparam int WL = 8, NUM = 4, DEPTH = 1000, AW = 10;

   typedef struct packed {
      logic wa; logic [9:0] aa; logic [31:0] da;
      logic wb; logic [9:0] ab; logic [31:0] db;
      logic ra; logic [9:0] raa;
      logic rb; logic [9:0] rab;
      logic sw;
   } vin_t;
   typedef struct packed {
      logic qva; logic [31:0] qa; logic ha;
      logic qvb; logic [31:0] qb; logic hb;
      logic wbk; logic col;
   } vout_t;
   typedef struct packed { vin_t i; vout_t o; } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_miss = 0;
   vec_t tbl [16];

   always #5 clk = ~clk;

   source_feature_buffer_if #(.VW(WL*NUM), .AW(AW)) bus1 ();
   source_feature_buffer_if #(.VW(WL*NUM), .AW(AW)) bus2 ();

   source_feature_buffer #(.WL(WL), .NUM(NUM), .DEPTH(DEPTH), .AW(AW), .RD_LAT(1)) dut1 (
      .clock(clk), .reset_n(rst_n), .bus(bus1));
   source_feature_buffer #(.WL(WL), .NUM(NUM), .DEPTH(DEPTH), .AW(AW), .RD_LAT(2)) dut2 (
      .clock(clk), .reset_n(rst_n), .bus(bus2));

   task automatic set1(input vin_t v);
      bus1.wren_a = v.wa; bus1.wradd_a = v.aa; bus1.data_a = v.da;
      bus1.wren_b = v.wb; bus1.wradd_b = v.ab; bus1.data_b = v.db;
      bus1.rden_a = v.ra; bus1.radd_a = v.raa;
      bus1.rden_b = v.rb; bus1.radd_b = v.rab;
      bus1.swap   = v.sw;
   endtask

   task automatic set2(input vin_t v);
      bus2.wren_a = v.wa; bus2.wradd_a = v.aa; bus2.data_a = v.da;
      bus2.wren_b = v.wb; bus2.wradd_b = v.ab; bus2.data_b = v.db;
      bus2.rden_a = v.ra; bus2.radd_a = v.raa;
      bus2.rden_b = v.rb; bus2.radd_b = v.rab;
      bus2.swap   = v.sw;
   endtask

   function automatic vout_t obs1();
      return '{bus1.qvalid_a, bus1.q_a, bus1.hit_a, bus1.qvalid_b, bus1.q_b, bus1.hit_b,
               bus1.wr_bank, bus1.collision};
   endfunction

   function automatic vout_t obs2();
      return '{bus2.qvalid_a, bus2.q_a, bus2.hit_a, bus2.qvalid_b, bus2.q_b, bus2.hit_b,
               bus2.wr_bank, bus2.collision};
   endfunction

   task automatic chk(input string nm, input vout_t act, input vout_t exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got qva=%b qa=%0d ha=%b qvb=%b qb=%0d hb=%b wb=%b col=%b, expected qva=%b qa=%0d ha=%b qvb=%b qb=%0d hb=%b wb=%b col=%b",
                  nm, act.qva, act.qa, act.ha, act.qvb, act.qb, act.hb, act.wbk, act.col,
                  exp.qva, exp.qa, exp.ha, exp.qvb, exp.qb, exp.hb, exp.wbk, exp.col);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vin_t idle, sw;
      idle = '0;
      sw   = '0;
      sw.sw = 1'b1;

      //          wa aa    da  wb ab  db  ra raa   rb rab  sw     qva qa  ha qvb qb  hb wb col
      tbl[0]  = '{'{1, 1,  111, 1, 2, 123, 0, 0,   0, 0,   0}, '{0, 0,   0, 0, 0,   0, 0, 0}};
      tbl[1]  = '{'{0, 0,  0,   0, 0, 0,   0, 0,   0, 0,   1}, '{0, 0,   0, 0, 0,   0, 1, 0}};
      tbl[2]  = '{'{0, 0,  0,   0, 0, 0,   1, 1,   1, 2,   0}, '{1, 111, 1, 1, 123, 1, 1, 0}};
      tbl[3]  = '{'{0, 0,  0,   0, 0, 0,   0, 0,   0, 0,   0}, '{0, 111, 1, 0, 123, 1, 1, 0}};
      tbl[4]  = '{'{1, 7,  5,   1, 7, 9,   0, 0,   0, 0,   0}, '{0, 111, 1, 0, 123, 1, 1, 1}};
      tbl[5]  = '{'{0, 0,  0,   0, 0, 0,   0, 0,   0, 0,   1}, '{0, 111, 1, 0, 123, 1, 0, 0}};
      tbl[6]  = '{'{0, 0,  0,   0, 0, 0,   1, 7,   0, 0,   0}, '{1, 5,   1, 0, 123, 1, 0, 0}};
      tbl[7]  = '{'{0, 0,  0,   0, 0, 0,   0, 0,   0, 0,   1}, '{0, 5,   1, 0, 123, 1, 1, 0}};
      tbl[8]  = '{'{0, 0,  0,   0, 0, 0,   1, 1,   1, 2,   0}, '{1, 111, 0, 1, 123, 0, 1, 0}};
      tbl[9]  = '{'{1, 10, 77,  0, 0, 0,   1, 1,   1, 2,   1}, '{1, 111, 0, 1, 123, 0, 0, 0}};
      tbl[10] = '{'{0, 0,  0,   0, 0, 0,   1, 10,  0, 0,   0}, '{1, 77,  1, 0, 123, 0, 0, 0}};
      tbl[11] = '{'{1, 1000, 55, 0, 0, 0,  0, 0,   1, 1000, 0}, '{0, 77, 1, 1, 0,   0, 0, 0}};
      tbl[12] = '{'{1, 999, 66, 1, 999, 44, 0, 0,  0, 0,   0}, '{0, 77,  1, 0, 0,   0, 0, 1}};
      tbl[13] = '{'{0, 0,  0,   0, 0, 0,   0, 0,   0, 0,   1}, '{0, 77,  1, 0, 0,   0, 1, 0}};
      tbl[14] = '{'{0, 0,  0,   0, 0, 0,   1, 999, 1, 999, 0}, '{1, 66,  1, 1, 66,  1, 1, 0}};
      tbl[15] = '{'{0, 0,  0,   0, 0, 0,   1, 1023, 0, 0,  0}, '{1, 0,   0, 0, 66,  1, 1, 0}};

      set1(idle);
      set2(idle);
      rst_n = 1'b0;
      #2;
      chk("reset_d1", obs1(), '0);
      chk("reset_d2", obs2(), '0);
      #10 rst_n = 1'b1;

      for (int k = 0; k < 16; k++) begin
         set1(tbl[k].i);
         tick();
         chk($sformatf("vec%0d", k), obs1(), tbl[k].o);
      end
      set1(idle);

      // RD_LAT=2: fill bank 0, swap, then a 3-deep burst with a swap+write on the last request edge.
      set2('{1, 3, 30, 1, 4, 40, 0, 0, 0, 0, 0}); tick(); chk("d2_wr0", obs2(), '0);
      set2('{1, 5, 50, 0, 0, 0,  0, 0, 0, 0, 0}); tick(); chk("d2_wr1", obs2(), '0);
      set2(sw);                                   tick(); chk("d2_swap", obs2(), '{0, 0, 0, 0, 0, 0, 1, 0});
      set2('{0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0});   tick(); chk("lat2_r0", obs2(), '{0, 0, 0, 0, 0, 0, 1, 0});
      set2('{0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0});   tick(); chk("lat2_r1", obs2(), '{1, 30, 1, 0, 0, 0, 1, 0});
      set2('{1, 10, 99, 0, 0, 0, 1, 5, 0, 0, 1}); tick(); chk("lat2_r2", obs2(), '{1, 40, 1, 0, 0, 0, 0, 0});
      set2(idle);                                 tick(); chk("lat2_r3", obs2(), '{1, 50, 1, 0, 0, 0, 0, 0});
      tick(); chk("lat2_hold", obs2(), '{0, 50, 1, 0, 0, 0, 0, 0});
      set2('{0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0});  tick(); chk("lat2_swr0", obs2(), '{0, 50, 1, 0, 0, 0, 0, 0});
      set2(idle);                                 tick(); chk("lat2_swr1", obs2(), '{1, 99, 1, 0, 0, 0, 0, 0});

      // Reset with reads in flight and a collision pulse showing.
      set2('{0, 0, 0, 0, 0, 0, 1, 10, 1, 10, 0}); tick(); chk("pre_rst0", obs2(), '{0, 99, 1, 0, 0, 0, 0, 0});
      set1('{1, 5, 1, 1, 5, 2, 0, 0, 0, 0, 0});   tick();
      chk("pre_rst1_d2", obs2(), '{1, 99, 1, 1, 99, 1, 0, 0});
      chk("pre_rst1_d1", obs1(), '{0, 0, 0, 0, 66, 1, 1, 1});
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_d1", obs1(), '0);
      chk("async_rst_d2", obs2(), '0);
      set1(idle);
      set2(idle);
      #2 rst_n = 1'b1;
      tick();
      chk("flush_d1", obs1(), '0);
      chk("flush_d2", obs2(), '0);
      set1('{0, 0, 0, 0, 0, 0, 1, 10, 1, 1000, 0});
      set2('{0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0});
      tick();
      chk("post_rst_d1", obs1(), '{1, 77, 0, 1, 0, 0, 0, 0});
      chk("post_rst_d2a", obs2(), '0);
      set1(idle);
      set2(idle);
      tick();
      chk("post_rst_d1h", obs1(), '{0, 77, 0, 0, 0, 0, 0, 0});
      chk("post_rst_d2b", obs2(), '{1, 99, 0, 0, 0, 0, 0, 0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/source_feature_buffer.md
Name: source_feature_buffer

Overview:
- Parametrised successor to the 2W/2R source feature buffer; stores NUM×WL-bit source-node feature vectors for the aggregation datapath.
- Adds ping-pong banking: the loader writes one bank while the PE array reads the other. Adds per-entry written-tags, deterministic write-collision resolution, configurable read latency and read-valid outputs.
- Sits between the DDR feature loader (write side) and the aggregation PEs (read side).

Parameters:
- WL, 32, bits per feature element
- NUM, 128, elements per vector; vector width VW = WL*NUM
- DEPTH, 1024, entries per bank; need not be a power of two
- AW, $clog2(DEPTH), address width (derived)
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2 only

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- data_a  in  VW  write data, port A
- wradd_a  in  AW  write address, port A
- wren_a  in  1  write enable, port A
- data_b  in  VW  write data, port B
- wradd_b  in  AW  write address, port B
- wren_b  in  1  write enable, port B
- radd_a  in  AW  read address, port A
- rden_a  in  1  read request, port A
- radd_b  in  AW  read address, port B
- rden_b  in  1  read request, port B
- swap  in  1  exchange the write and read banks
- q_a  out  VW  read data, port A
- q_b  out  VW  read data, port B
- qvalid_a  out  1  q_a is valid this cycle
- qvalid_b  out  1  q_b is valid this cycle
- hit_a  out  1  entry read on port A was written since its bank became the write bank
- hit_b  out  1  entry read on port B was written since its bank became the write bank
- wr_bank  out  1  index of the current write bank
- collision  out  1  one-cycle pulse: A and B wrote the same address

Behaviour:
- Reset (asynchronous, reset_n=0): wr_bank=0; all tag bits in both banks=0; q_a/q_b=0; qvalid_*=0; hit_*=0; collision=0. RAM contents are not reset. Read pipelines are flushed, and in-flight reads are dropped.
- Write bank is wr_bank; read bank is ~wr_bank. Writes only target the write bank; reads only source the read bank. Because the banks never overlap, no read-during-write bypass exists.
- Write: at edge t with wren_x=1 and wradd_x<DEPTH, mem[wr_bank][wradd_x]<=data_x and tag[wr_bank][wradd_x]<=1. If wradd_x>=DEPTH, the write is ignored and nothing else changes.
- Collision: when wren_a & wren_b and wradd_a==wradd_b (in range), port A wins and B's write is discarded. collision=1 for the one cycle after edge t; otherwise collision=0.
- Read: rden_x sampled at edge t. Data, tag and qvalid_x appear after RD_LAT edges: qvalid_x=1 in the cycle following edge t+RD_LAT-1, for one cycle per request. Back-to-back requests give one result per cycle.
- Read results: hit_x = tag of the addressed entry. An out-of-range read returns q_x=0, hit_x=0, qvalid_x=1.
- Output hold: when qvalid_x=0, q_x and hit_x hold their last values.
- Swap: at edge t with swap=1, wr_bank toggles and every tag of the new write bank (the old read bank) clears to 0. Data is not cleared.
- Swap with same-edge activity: writes at edge t land in the pre-swap write bank and set their tags. Reads sampled at t use the pre-swap read bank, even when RD_LAT=2 and the data emerges after the swap.
- Ports A and B are fully independent and may read the same address in the same cycle.

Decomposition:
- Package source_buffer_pkg holds the default WL/NUM/DEPTH constants, typedef feat_vec_t (logic [WL*NUM-1:0]) and typedef bank_sel_t.
- One sub-module, sb_bank_ram: a single 2W/2R bank with an RD_LAT output register stage, instantiated twice.
- The top level owns wr_bank, the tag arrays, collision detection, read-bank muxing and the qvalid/hit pipelines.

Test Plan:
1. Write A: 111 @1, write B: 123 @2; swap; rden_a @1, rden_b @2 (RD_LAT=1) -> next cycle q_a=111, q_b=123, hit_a=hit_b=1, qvalid_a=qvalid_b=1 for exactly one cycle; wr_bank=1.
2. Same-cycle wren_a (data 5) and wren_b (data 9), both @7; swap; read @7 -> q=5, hit=1; collision=1 for exactly one cycle after the write edge.
3. After test 1, swap twice without writing bank 0; read @1 -> q=111 (data retained), hit=0.
4. RD_LAT=2: rden_a=1 @3,@4,@5 on consecutive cycles -> qvalid_a high for 3 consecutive cycles starting 2 cycles after the first request, data in request order.
5. Swap asserted on the same edge as a write @10 and a read -> write lands in the old write bank (readable with hit=1 after the swap); the read returns old read-bank data.
6. Assert reset_n=0 mid-stream with reads in flight -> qvalid_*, collision and wr_bank go to 0 immediately; after release, reads of previously written addresses return hit=0; a read with wradd/radd=DEPTH (non-power-of-two DEPTH=1000) -> q=0, hit=0.
